// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-subset control unit: state and
// cause enums, opcode/funct codes, ALU selector codes, datapath mux encodings
// and the packed control-word payload that drives the datapath nets.
package mc_ctrl_pkg;

    localparam int unsigned OPC_W    = 6;
    localparam int unsigned FN_W     = 6;
    localparam int unsigned ALU_OP_W = 3;
    localparam int unsigned ADDR_W   = 8;

    // Datapath constants selected by this unit (the values live in the datapath)
    localparam logic [ADDR_W-1:0] SP_INIT  = ADDR_W'(227);
    localparam logic [ADDR_W-1:0] VEC_OPC  = ADDR_W'(253);
    localparam logic [ADDR_W-1:0] VEC_OVF  = ADDR_W'(254);
    localparam logic [ADDR_W-1:0] VEC_DIV0 = ADDR_W'(255);

    typedef enum logic [4:0] {
        S_RESET, S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
        S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_ADDR, S_MEMRD, S_MEMWAIT, S_MDR, S_WB_LW, S_MEMWR,
        S_BR, S_JUMP, S_JAL, S_JR, S_LUI, S_MFHI, S_MFLO,
        S_MD_START, S_WAIT_MD,
        S_EXC_EPC, S_EXC_RD, S_EXC_WAIT, S_EXC_MDR, S_EXC_PC
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE, CAUSE_OPC, CAUSE_OVF, CAUSE_DIV0
    } cause_e;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OP_J     = 6'h02;
    localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FN_W-1:0] FN_JR   = 6'h08;
    localparam logic [FN_W-1:0] FN_MFHI = 6'h10;
    localparam logic [FN_W-1:0] FN_MFLO = 6'h12;
    localparam logic [FN_W-1:0] FN_MULT = 6'h18;
    localparam logic [FN_W-1:0] FN_DIV  = 6'h1A;
    localparam logic [FN_W-1:0] FN_ADD  = 6'h20;
    localparam logic [FN_W-1:0] FN_SUB  = 6'h22;
    localparam logic [FN_W-1:0] FN_AND  = 6'h24;

    localparam logic [ALU_OP_W-1:0] ALU_LOAD = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_INC  = 3'b100;
    localparam logic [ALU_OP_W-1:0] ALU_NOT  = 3'b101;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 3'b110;
    localparam logic [ALU_OP_W-1:0] ALU_CMP  = 3'b111;

    localparam logic [1:0] COND_Z  = 2'b00;
    localparam logic [1:0] COND_NZ = 2'b01;

    localparam logic [2:0] PCS_ALU    = 3'b000;
    localparam logic [2:0] PCS_ALUOUT = 3'b001;
    localparam logic [2:0] PCS_JUMP   = 3'b010;
    localparam logic [2:0] PCS_A      = 3'b011;
    localparam logic [2:0] PCS_MDR    = 3'b100;
    localparam logic [2:0] PCS_EPC    = 3'b101;

    localparam logic [2:0] IORD_PC       = 3'b000;
    localparam logic [2:0] IORD_ALUOUT   = 3'b001;
    localparam logic [2:0] IORD_VEC_OPC  = 3'b010;
    localparam logic [2:0] IORD_VEC_OVF  = 3'b011;
    localparam logic [2:0] IORD_VEC_DIV0 = 3'b100;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;
    localparam logic [1:0] DST_SP = 2'b11;

    localparam logic [2:0] M2R_ALUOUT = 3'b000;
    localparam logic [2:0] M2R_MDR    = 3'b001;
    localparam logic [2:0] M2R_HI     = 3'b010;
    localparam logic [2:0] M2R_LO     = 3'b011;
    localparam logic [2:0] M2R_PC     = 3'b100;
    localparam logic [2:0] M2R_LUI    = 3'b101;
    localparam logic [2:0] M2R_SP     = 3'b110;

    localparam logic       SRCA_PC       = 1'b0;
    localparam logic       SRCA_A        = 1'b1;
    localparam logic [1:0] SRCB_B        = 2'b00;
    localparam logic [1:0] SRCB_4        = 2'b01;
    localparam logic [1:0] SRCB_SEXT     = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

    // Full datapath control word
    typedef struct packed {
        logic                pc_write;
        logic                pc_write_cond;
        logic [1:0]          pc_cond_sel;
        logic [2:0]          pc_source_sel;
        logic [2:0]          iord_sel;
        logic                mem_wr;
        logic                ir_write;
        logic                mdr_load;
        logic                reg_write;
        logic [1:0]          reg_dst_sel;
        logic [2:0]          mem_to_reg_sel;
        logic                a_load;
        logic                b_load;
        logic                alu_out_load;
        logic                epc_write;
        logic                hi_load;
        logic                lo_load;
        logic                alu_src_a_sel;
        logic [1:0]          alu_src_b_sel;
        logic [ALU_OP_W-1:0] alu_op;
        logic                mult_start;
        logic                div_start;
        logic                divmult_sel;
    } ctrl_t;

    // Memory address select for the handler vector of a latched cause
    function automatic logic [2:0] cause_vector(input cause_e cause);
        case (cause)
            CAUSE_OVF:  return IORD_VEC_OVF;
            CAUSE_DIV0: return IORD_VEC_DIV0;
            default:    return IORD_VEC_OPC;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Multicycle control unit: Moore FSM sequencing fetch, decode, execute and the
// exception entry path, plus the Mult/Div start/done handshake.
// Ports:
//   clock, reset          - clock, synchronous active-high reset
//   opcode, funct         - IR[31:26], IR[5:0]
//   zero, overflow        - ALU flags of the current cycle
//   mult_done, div_done, div_zero - Mult/Div status
//   all other outputs     - datapath load enables, mux selects, ALU selector
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [OPC_W-1:0]    opcode,
    input  logic [FN_W-1:0]     funct,
    input  logic                zero,
    input  logic                overflow,
    input  logic                mult_done,
    input  logic                div_done,
    input  logic                div_zero,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          pc_cond_sel,
    output logic [2:0]          pc_source_sel,
    output logic [2:0]          iord_sel,
    output logic                mem_wr,
    output logic                ir_write,
    output logic                mdr_load,
    output logic                reg_write,
    output logic [1:0]          reg_dst_sel,
    output logic [2:0]          mem_to_reg_sel,
    output logic                a_load,
    output logic                b_load,
    output logic                alu_out_load,
    output logic                epc_write,
    output logic                hi_load,
    output logic                lo_load,
    output logic                alu_src_a_sel,
    output logic [1:0]          alu_src_b_sel,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                mult_start,
    output logic                div_start,
    output logic                divmult_sel
);

    state_e state_q, state_d;
    cause_e cause_q, cause_d;
    ctrl_t  ctrl;
    logic   is_div;
    logic   md_done;
    logic   unused_zero;

    // zero qualifies branches inside the datapath via pc_write_cond
    assign unused_zero = zero;
    assign is_div      = (funct == FN_DIV);
    assign md_done     = is_div ? div_done : mult_done;

    // Moore control word for each state
    function automatic ctrl_t decode_outputs(input state_e st, input logic [OPC_W-1:0] opc,
                                             input logic [FN_W-1:0] fn, input cause_e cause);
        ctrl_t c;
        c = '0;
        case (st)
            S_RESET: begin
                c.reg_write      = 1'b1;
                c.reg_dst_sel    = DST_SP;
                c.mem_to_reg_sel = M2R_SP;
            end
            // ALU keeps PC+4 through the read wait so FETCH2 can latch it
            S_FETCH0, S_FETCH1, S_FETCH2: begin
                c.iord_sel      = IORD_PC;
                c.alu_src_a_sel = SRCA_PC;
                c.alu_src_b_sel = SRCB_4;
                c.alu_op        = ALU_ADD;
                if (st == S_FETCH2) begin
                    c.ir_write      = 1'b1;
                    c.pc_write      = 1'b1;
                    c.pc_source_sel = PCS_ALU;
                end
            end
            S_DECODE: begin
                c.a_load        = 1'b1;
                c.b_load        = 1'b1;
                c.alu_out_load  = 1'b1;
                c.alu_src_a_sel = SRCA_PC;
                c.alu_src_b_sel = SRCB_SEXT_SH2;
                c.alu_op        = ALU_ADD;
            end
            S_EXEC_R: begin
                c.alu_src_a_sel = SRCA_A;
                c.alu_src_b_sel = SRCB_B;
                c.alu_out_load  = 1'b1;
                c.alu_op        = (fn == FN_SUB) ? ALU_SUB : ((fn == FN_AND) ? ALU_AND : ALU_ADD);
            end
            S_WB_R: begin
                c.reg_write      = 1'b1;
                c.reg_dst_sel    = DST_RD;
                c.mem_to_reg_sel = M2R_ALUOUT;
            end
            S_EXEC_I, S_ADDR: begin
                c.alu_src_a_sel = SRCA_A;
                c.alu_src_b_sel = SRCB_SEXT;
                c.alu_out_load  = 1'b1;
                c.alu_op        = ALU_ADD;
            end
            S_WB_I: begin
                c.reg_write      = 1'b1;
                c.reg_dst_sel    = DST_RT;
                c.mem_to_reg_sel = M2R_ALUOUT;
            end
            S_MEMRD:  c.iord_sel = IORD_ALUOUT;
            S_MDR:    c.mdr_load = 1'b1;
            S_WB_LW: begin
                c.reg_write      = 1'b1;
                c.reg_dst_sel    = DST_RT;
                c.mem_to_reg_sel = M2R_MDR;
            end
            S_MEMWR: begin
                c.iord_sel = IORD_ALUOUT;
                c.mem_wr   = 1'b1;
            end
            S_BR: begin
                c.alu_src_a_sel = SRCA_A;
                c.alu_src_b_sel = SRCB_B;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_cond_sel   = (opc == OP_BNE) ? COND_NZ : COND_Z;
                c.pc_source_sel = PCS_ALUOUT;
            end
            S_JUMP: begin
                c.pc_write      = 1'b1;
                c.pc_source_sel = PCS_JUMP;
            end
            // PC already holds PC+4 here; the bank samples it before the jump lands
            S_JAL: begin
                c.pc_write       = 1'b1;
                c.pc_source_sel  = PCS_JUMP;
                c.reg_write      = 1'b1;
                c.reg_dst_sel    = DST_RA;
                c.mem_to_reg_sel = M2R_PC;
            end
            S_JR: begin
                c.pc_write      = 1'b1;
                c.pc_source_sel = PCS_A;
            end
            S_LUI: begin
                c.reg_write      = 1'b1;
                c.reg_dst_sel    = DST_RT;
                c.mem_to_reg_sel = M2R_LUI;
            end
            S_MFHI, S_MFLO: begin
                c.reg_write      = 1'b1;
                c.reg_dst_sel    = DST_RD;
                c.mem_to_reg_sel = (st == S_MFHI) ? M2R_HI : M2R_LO;
            end
            S_MD_START: begin
                c.mult_start = (fn == FN_MULT);
                c.div_start  = (fn == FN_DIV);
            end
            S_EXC_EPC: begin
                c.alu_src_a_sel = SRCA_PC;
                c.alu_src_b_sel = SRCB_4;
                c.alu_op        = ALU_SUB;
                c.epc_write     = 1'b1;
            end
            S_EXC_RD:  c.iord_sel = cause_vector(cause);
            S_EXC_MDR: c.mdr_load = 1'b1;
            S_EXC_PC: begin
                c.pc_write      = 1'b1;
                c.pc_source_sel = PCS_MDR;
            end
            default: ;
        endcase
        return c;
    endfunction

    // State and exception-cause registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_RESET;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Next state, cause capture and control word
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        ctrl    = decode_outputs(state_q, opcode, funct, cause_q);
        case (state_q)
            S_RESET:   state_d = S_FETCH0;
            S_FETCH0:  state_d = S_FETCH1;
            S_FETCH1:  state_d = S_FETCH2;
            S_FETCH2:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD, FN_SUB, FN_AND: state_d = S_EXEC_R;
                            FN_JR:                  state_d = S_JR;
                            FN_MFHI:                state_d = S_MFHI;
                            FN_MFLO:                state_d = S_MFLO;
                            FN_MULT, FN_DIV:        state_d = S_MD_START;
                            default: begin
                                state_d = S_EXC_EPC;
                                cause_d = CAUSE_OPC;
                            end
                        endcase
                    end
                    OP_ADDI:        state_d = S_EXEC_I;
                    OP_LW, OP_SW:   state_d = S_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BR;
                    OP_J:           state_d = S_JUMP;
                    OP_JAL:         state_d = S_JAL;
                    OP_LUI:         state_d = S_LUI;
                    default: begin
                        state_d = S_EXC_EPC;
                        cause_d = CAUSE_OPC;
                    end
                endcase
            end
            // and never traps on overflow
            S_EXEC_R: begin
                if (overflow && (funct != FN_AND)) begin
                    state_d = S_EXC_EPC;
                    cause_d = CAUSE_OVF;
                end else begin
                    state_d = S_WB_R;
                end
            end
            S_EXEC_I: begin
                if (overflow) begin
                    state_d = S_EXC_EPC;
                    cause_d = CAUSE_OVF;
                end else begin
                    state_d = S_WB_I;
                end
            end
            S_ADDR:    state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWAIT;
            S_MEMWAIT: state_d = S_MDR;
            S_MDR:     state_d = S_WB_LW;
            S_MD_START: state_d = S_WAIT_MD;
            // div_zero wins over a same-cycle done and suppresses the HI/LO load
            S_WAIT_MD: begin
                if (div_zero) begin
                    state_d = S_EXC_EPC;
                    cause_d = CAUSE_DIV0;
                end else if (md_done) begin
                    ctrl.hi_load     = 1'b1;
                    ctrl.lo_load     = 1'b1;
                    ctrl.divmult_sel = is_div;
                    state_d          = S_FETCH0;
                end
            end
            S_EXC_EPC:  state_d = S_EXC_RD;
            S_EXC_RD:   state_d = S_EXC_WAIT;
            S_EXC_WAIT: state_d = S_EXC_MDR;
            S_EXC_MDR:  state_d = S_EXC_PC;
            default:    state_d = S_FETCH0;
        endcase
    end

    assign pc_write       = ctrl.pc_write;
    assign pc_write_cond  = ctrl.pc_write_cond;
    assign pc_cond_sel    = ctrl.pc_cond_sel;
    assign pc_source_sel  = ctrl.pc_source_sel;
    assign iord_sel       = ctrl.iord_sel;
    assign mem_wr         = ctrl.mem_wr;
    assign ir_write       = ctrl.ir_write;
    assign mdr_load       = ctrl.mdr_load;
    assign reg_write      = ctrl.reg_write;
    assign reg_dst_sel    = ctrl.reg_dst_sel;
    assign mem_to_reg_sel = ctrl.mem_to_reg_sel;
    assign a_load         = ctrl.a_load;
    assign b_load         = ctrl.b_load;
    assign alu_out_load   = ctrl.alu_out_load;
    assign epc_write      = ctrl.epc_write;
    assign hi_load        = ctrl.hi_load;
    assign lo_load        = ctrl.lo_load;
    assign alu_src_a_sel  = ctrl.alu_src_a_sel;
    assign alu_src_b_sel  = ctrl.alu_src_b_sel;
    assign alu_op         = ctrl.alu_op;
    assign mult_start     = ctrl.mult_start;
    assign div_start      = ctrl.div_start;
    assign divmult_sel    = ctrl.divmult_sel;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm. Each instruction is expanded into
// the list of control words the datapath must see, cycle by cycle, from the
// instruction's step list; a compare process checks the DUT every cycle.
module tb_mc_control_fsm;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_cond_sel;
        logic [2:0] pc_source_sel;
        logic [2:0] iord_sel;
        logic       mem_wr;
        logic       ir_write;
        logic       mdr_load;
        logic       reg_write;
        logic [1:0] reg_dst_sel;
        logic [2:0] mem_to_reg_sel;
        logic       a_load;
        logic       b_load;
        logic       alu_out_load;
        logic       epc_write;
        logic       hi_load;
        logic       lo_load;
        logic       alu_src_a_sel;
        logic [1:0] alu_src_b_sel;
        logic [2:0] alu_op;
        logic       mult_start;
        logic       div_start;
        logic       divmult_sel;
    } sig_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       overflow = 1'b0;
    logic       mult_done = 1'b0;
    logic       div_done = 1'b0;
    logic       div_zero = 1'b0;

    logic       pc_write, pc_write_cond, mem_wr, ir_write, mdr_load, reg_write;
    logic [1:0] pc_cond_sel, reg_dst_sel, alu_src_b_sel;
    logic [2:0] pc_source_sel, iord_sel, mem_to_reg_sel, alu_op;
    logic       a_load, b_load, alu_out_load, epc_write, hi_load, lo_load;
    logic       alu_src_a_sel, mult_start, div_start, divmult_sel;

    sig_t act;
    sig_t exp_cur = '0;
    logic exp_valid = 1'b0;
    int   exp_tag = 0;
    int   exp_cyc = 0;
    logic stim_done = 1'b0;
    int   total = 0;
    int   passed = 0;

    always #5 clock = ~clock;

    mc_control_fsm dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .overflow(overflow), .mult_done(mult_done),
        .div_done(div_done), .div_zero(div_zero),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_cond_sel(pc_cond_sel),
        .pc_source_sel(pc_source_sel), .iord_sel(iord_sel), .mem_wr(mem_wr),
        .ir_write(ir_write), .mdr_load(mdr_load), .reg_write(reg_write),
        .reg_dst_sel(reg_dst_sel), .mem_to_reg_sel(mem_to_reg_sel),
        .a_load(a_load), .b_load(b_load), .alu_out_load(alu_out_load),
        .epc_write(epc_write), .hi_load(hi_load), .lo_load(lo_load),
        .alu_src_a_sel(alu_src_a_sel), .alu_src_b_sel(alu_src_b_sel), .alu_op(alu_op),
        .mult_start(mult_start), .div_start(div_start), .divmult_sel(divmult_sel)
    );

    always_comb begin
        act                = '0;
        act.pc_write       = pc_write;
        act.pc_write_cond  = pc_write_cond;
        act.pc_cond_sel    = pc_cond_sel;
        act.pc_source_sel  = pc_source_sel;
        act.iord_sel       = iord_sel;
        act.mem_wr         = mem_wr;
        act.ir_write       = ir_write;
        act.mdr_load       = mdr_load;
        act.reg_write      = reg_write;
        act.reg_dst_sel    = reg_dst_sel;
        act.mem_to_reg_sel = mem_to_reg_sel;
        act.a_load         = a_load;
        act.b_load         = b_load;
        act.alu_out_load   = alu_out_load;
        act.epc_write      = epc_write;
        act.hi_load        = hi_load;
        act.lo_load        = lo_load;
        act.alu_src_a_sel  = alu_src_a_sel;
        act.alu_src_b_sel  = alu_src_b_sel;
        act.alu_op         = alu_op;
        act.mult_start     = mult_start;
        act.div_start      = div_start;
        act.divmult_sel    = divmult_sel;
    end

    function automatic sig_t reset_word();
        sig_t s;
        s = '0;
        s.reg_write      = 1'b1;
        s.reg_dst_sel    = 2'b11;
        s.mem_to_reg_sel = 3'b110;
        return s;
    endfunction

    // Expected control words, one per cycle, from FETCH0 to the last cycle
    task automatic build_plan(input logic [5:0] op, input logic [5:0] fn, input logic ovf,
                              input int ev_at, input logic ev_dz, output sig_t q[$]);
        sig_t s;
        logic [2:0] exc_vec;
        logic rtype;
        q.delete();
        exc_vec = 3'b000;
        rtype = (op == 6'h00);
        s = '0; s.alu_src_b_sel = 2'b01; s.alu_op = 3'b001;
        q.push_back(s);
        q.push_back(s);
        s.ir_write = 1'b1; s.pc_write = 1'b1;
        q.push_back(s);
        s = '0; s.a_load = 1'b1; s.b_load = 1'b1; s.alu_out_load = 1'b1;
        s.alu_src_b_sel = 2'b11; s.alu_op = 3'b001;
        q.push_back(s);
        s = '0;
        if (rtype && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
            s.alu_src_a_sel = 1'b1; s.alu_out_load = 1'b1;
            s.alu_op = (fn == 6'h22) ? 3'b010 : ((fn == 6'h24) ? 3'b011 : 3'b001);
            q.push_back(s);
            if (ovf && fn != 6'h24) exc_vec = 3'b011;
            else begin s = '0; s.reg_write = 1'b1; s.reg_dst_sel = 2'b01; q.push_back(s); end
        end else if (rtype && fn == 6'h08) begin
            s.pc_write = 1'b1; s.pc_source_sel = 3'b011; q.push_back(s);
        end else if (rtype && (fn == 6'h10 || fn == 6'h12)) begin
            s.reg_write = 1'b1; s.reg_dst_sel = 2'b01;
            s.mem_to_reg_sel = (fn == 6'h10) ? 3'b010 : 3'b011;
            q.push_back(s);
        end else if (rtype && (fn == 6'h18 || fn == 6'h1A)) begin
            s.mult_start = (fn == 6'h18); s.div_start = (fn == 6'h1A);
            q.push_back(s);
            for (int c = 6; c <= ev_at; c++) begin
                s = '0;
                if (c == ev_at && !ev_dz) begin
                    s.hi_load = 1'b1; s.lo_load = 1'b1; s.divmult_sel = (fn == 6'h1A);
                end
                q.push_back(s);
            end
            if (ev_dz) exc_vec = 3'b100;
        end else if (rtype) begin
            exc_vec = 3'b010;
        end else if (op == 6'h08) begin
            s.alu_src_a_sel = 1'b1; s.alu_src_b_sel = 2'b10; s.alu_op = 3'b001; s.alu_out_load = 1'b1;
            q.push_back(s);
            if (ovf) exc_vec = 3'b011;
            else begin s = '0; s.reg_write = 1'b1; q.push_back(s); end
        end else if (op == 6'h23 || op == 6'h2B) begin
            s.alu_src_a_sel = 1'b1; s.alu_src_b_sel = 2'b10; s.alu_op = 3'b001; s.alu_out_load = 1'b1;
            q.push_back(s);
            s = '0; s.iord_sel = 3'b001; s.mem_wr = (op == 6'h2B);
            q.push_back(s);
            if (op == 6'h23) begin
                s = '0; q.push_back(s);
                s.mdr_load = 1'b1; q.push_back(s);
                s = '0; s.reg_write = 1'b1; s.mem_to_reg_sel = 3'b001; q.push_back(s);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            s.pc_write_cond = 1'b1; s.pc_cond_sel = (op == 6'h05) ? 2'b01 : 2'b00;
            s.pc_source_sel = 3'b001; s.alu_src_a_sel = 1'b1; s.alu_op = 3'b010;
            q.push_back(s);
        end else if (op == 6'h02 || op == 6'h03) begin
            s.pc_write = 1'b1; s.pc_source_sel = 3'b010;
            if (op == 6'h03) begin s.reg_write = 1'b1; s.reg_dst_sel = 2'b10; s.mem_to_reg_sel = 3'b100; end
            q.push_back(s);
        end else if (op == 6'h0F) begin
            s.reg_write = 1'b1; s.mem_to_reg_sel = 3'b101; q.push_back(s);
        end else begin
            exc_vec = 3'b010;
        end
        if (exc_vec != 3'b000) begin
            s = '0; s.epc_write = 1'b1; s.alu_src_b_sel = 2'b01; s.alu_op = 3'b010; q.push_back(s);
            s = '0; s.iord_sel = exc_vec; q.push_back(s);
            s = '0; q.push_back(s);
            s.mdr_load = 1'b1; q.push_back(s);
            s = '0; s.pc_write = 1'b1; s.pc_source_sel = 3'b100; q.push_back(s);
        end
    endtask

    // Drives one instruction; abort_at>0 raises reset in that cycle
    task automatic run_instr(input int tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic ovf, input int ev_at, input logic ev_dz, input int abort_at);
        sig_t q[$];
        int n;
        build_plan(op, fn, ovf, ev_at, ev_dz, q);
        n = (abort_at > 0) ? abort_at : q.size();
        for (int k = 1; k <= n; k++) begin
            @(posedge clock); #1;
            opcode    = op;
            funct     = fn;
            overflow  = ovf;
            div_done  = (op == 6'h00 && fn == 6'h1A && !ev_dz && k == ev_at);
            mult_done = (op == 6'h00 && fn == 6'h18 && !ev_dz && k == ev_at);
            div_zero  = ev_dz && (k == ev_at);
            if (abort_at > 0 && k == abort_at) reset = 1'b1;
            exp_cur = q[k-1]; exp_tag = tag; exp_cyc = k; exp_valid = 1'b1;
        end
        if (abort_at > 0) begin
            @(posedge clock); #1;
            reset = 1'b0;
            div_zero = 1'b0;
            exp_cur = reset_word(); exp_cyc = n + 1;
        end
    endtask

    // Stimulus: directed instruction sequence
    initial begin
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            exp_cur = reset_word(); exp_tag = 0; exp_cyc = i + 1; exp_valid = 1'b1;
        end
        reset = 1'b0;
        run_instr(1,  6'h00, 6'h20, 1'b0, 0,  1'b0, 0);  // add
        run_instr(2,  6'h00, 6'h20, 1'b1, 0,  1'b0, 0);  // add, overflow
        run_instr(3,  6'h00, 6'h22, 1'b0, 0,  1'b0, 0);  // sub
        run_instr(4,  6'h00, 6'h24, 1'b1, 0,  1'b0, 0);  // and ignores overflow
        run_instr(5,  6'h00, 6'h22, 1'b1, 0,  1'b0, 0);  // sub, overflow
        run_instr(6,  6'h08, 6'h3F, 1'b0, 0,  1'b0, 0);  // addi
        run_instr(7,  6'h08, 6'h00, 1'b1, 0,  1'b0, 0);  // addi, overflow
        run_instr(8,  6'h23, 6'h00, 1'b0, 0,  1'b0, 0);  // lw
        run_instr(9,  6'h2B, 6'h00, 1'b0, 0,  1'b0, 0);  // sw
        run_instr(10, 6'h04, 6'h00, 1'b0, 0,  1'b0, 0);  // beq
        run_instr(11, 6'h05, 6'h00, 1'b0, 0,  1'b0, 0);  // bne
        run_instr(12, 6'h02, 6'h00, 1'b0, 0,  1'b0, 0);  // j
        run_instr(13, 6'h03, 6'h00, 1'b0, 0,  1'b0, 0);  // jal
        run_instr(14, 6'h00, 6'h08, 1'b0, 0,  1'b0, 0);  // jr
        run_instr(15, 6'h0F, 6'h00, 1'b0, 0,  1'b0, 0);  // lui
        run_instr(16, 6'h00, 6'h10, 1'b0, 0,  1'b0, 0);  // mfhi
        run_instr(17, 6'h00, 6'h12, 1'b0, 0,  1'b0, 0);  // mflo
        run_instr(18, 6'h00, 6'h18, 1'b0, 10, 1'b0, 0);  // mult, done at cycle 10
        run_instr(19, 6'h00, 6'h1A, 1'b0, 37, 1'b0, 0);  // div, done 32 cycles after start
        run_instr(20, 6'h00, 6'h1A, 1'b0, 20, 1'b1, 0);  // div by zero
        run_instr(21, 6'h00, 6'h18, 1'b0, 8,  1'b1, 0);  // div_zero during mult wait
        run_instr(22, 6'h3F, 6'h00, 1'b0, 0,  1'b0, 0);  // undefined opcode
        run_instr(23, 6'h00, 6'h3F, 1'b0, 0,  1'b0, 0);  // undefined funct
        run_instr(24, 6'h3F, 6'h00, 1'b0, 0,  1'b0, 7);  // reset during EXC_WAIT
        run_instr(25, 6'h00, 6'h20, 1'b0, 0,  1'b0, 0);  // add after abort
        @(posedge clock); #1;
        exp_valid = 1'b0;
        stim_done = 1'b1;
    end

    task automatic check_int(input string name, input int a, input int e);
        total++;
        if (a == e) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, a, e);
    endtask

    // Compare process: pins the step lists to hand-derived values, then checks every cycle
    initial begin
        sig_t q[$];
        build_plan(6'h00, 6'h20, 1'b0, 0, 1'b0, q);
        check_int("add_latency", q.size(), 6);
        check_int("fetch_pc_write_cyc3", int'(q[2].pc_write), 1);
        check_int("add_wb_dst_rd", int'(q[5].reg_dst_sel), 1);
        build_plan(6'h00, 6'h20, 1'b1, 0, 1'b0, q);
        check_int("ovf_epc_cyc6", int'(q[5].epc_write), 1);
        check_int("ovf_vector_cyc7", int'(q[6].iord_sel), 3);
        check_int("ovf_pc_src_cyc10", int'(q[9].pc_source_sel), 4);
        build_plan(6'h23, 6'h00, 1'b0, 0, 1'b0, q);
        check_int("lw_latency", q.size(), 9);
        check_int("lw_mdr_cyc8", int'(q[7].mdr_load), 1);
        check_int("lw_m2r_cyc9", int'(q[8].mem_to_reg_sel), 1);
        build_plan(6'h2B, 6'h00, 1'b0, 0, 1'b0, q);
        check_int("sw_latency", q.size(), 6);
        check_int("sw_memwr_cyc6", int'(q[5].mem_wr), 1);
        build_plan(6'h05, 6'h00, 1'b0, 0, 1'b0, q);
        check_int("bne_latency", q.size(), 5);
        check_int("bne_cond_sel", int'(q[4].pc_cond_sel), 1);
        build_plan(6'h00, 6'h1A, 1'b0, 20, 1'b1, q);
        check_int("div0_vector", int'(q[21].iord_sel), 4);
        while (!stim_done) begin
            @(negedge clock);
            if (exp_valid) begin
                total++;
                if (act === exp_cur) passed++;
                else $display("FAIL trace case%0d cyc%0d: got %h expected %h",
                              exp_tag, exp_cyc, act, exp_cur);
            end
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

endmodule
